avg_pool_3d_bwd: RTL
====================

Name: avg_pool_3d_bwd

Overview:
- Backward (gradient) counterpart of the 3D average-pooling operator block.
- Accepts one pooled-output gradient per handshake and scales it by 1/(KD·KH·KW).
- Emits KD·KH·KW identical scaled gradient beats, one per window element, each tagged with its (kd,kh,kw) offset.
- Sits between the pooled-gradient stream and the input-gradient scatter/accumulate stage.

Parameters:
- DATA_W, 32, width of signed Q16.16 fixed-point gradient data.
- KD, 2, pooling window depth (≥1).
- KH, 2, pooling window height (≥1).
- KW, 2, pooling window width (≥1).
- Localparam N = KD·KH·KW.
- Localparam RECIP = round(65536/N), unsigned 17-bit Q1.16.
- Localparam IW_x = max(1, $clog2(Kx)), the index width for each of D, H, W.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  pooled-gradient beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_W  signed pooled gradient, Q16.16.
- in_last  in  1  last pooled gradient of tensor.
- out_valid  out  1  scaled gradient beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  DATA_W  scaled gradient, Q16.16.
- out_kd  out  IW_D  window depth offset.
- out_kh  out  IW_H  window height offset.
- out_kw  out  IW_W  window width offset.
- out_last  out  1  final beat of window whose input carried in_last.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (async assert, sync-safe release):
  - State goes to IDLE.
  - out_valid, out_data, out_kd/kh/kw, out_last, busy all = 0; in_ready = 1 once rst is low.
  - Reset mid-window discards the remainder of the window; no further beats are emitted.
- FSM states:
  - IDLE: in_ready = 1. On in_valid&&in_ready, capture in_data and in_last into hold registers and go to SCALE.
  - SCALE: in_ready = 0. Register the scaled value, clear index counters, go to EMIT.
  - EMIT: in_ready = 0, out_valid = 1. On out_valid&&out_ready, advance the indices. After the final beat, go to IDLE.
- Latency and throughput:
  - First out_valid is asserted 2 clk edges after the accept edge.
  - Throughput is one window per N+2 cycles with out_ready held high.
- Index order:
  - kw is fastest, then kh, then kd: (0,0,0),(0,0,1),…,(KD-1,KH-1,KW-1).
  - Each counter wraps to 0 when its faster neighbour wraps.
  - The final beat is all three indices at maximum.
- Backpressure: while out_valid&&!out_ready, out_data, indices and out_last hold stable. No beat is dropped or duplicated.
- out_last: asserted only on the final beat (all indices max) and only if the captured in_last = 1. It is 0 on all other beats.
- Arithmetic:
  - prod = signed(in_data) × {1'b0,RECIP}, computed at full DATA_W+18 bits, signed.
  - out_data = prod >>> 16 (arithmetic shift), rounding per the optional feature.
  - Overflow is impossible because RECIP ≤ 65536. N=1 gives an exact passthrough.
- Simultaneous events: in_valid is ignored outside IDLE, and the upstream must hold the beat.
- No bubble-free back-to-back accept: the cycle after the final EMIT beat is IDLE.

Optional Feature:
- Macro: AVGPOOL3D_BWD_ROUND_EN.
- Defined: round-half-up. out_data = (prod + 32768) >>> 16.
- Undefined: truncation toward −∞. out_data = prod >>> 16.
- The macro affects only the SCALE computation. Timing and handshake behaviour are identical in both builds.

Test Plan:
- Basic window: KD=KH=KW=2, in_data=0x00080000 (8.0), in_last=0, out_ready=1 → 8 beats of 0x00010000, indices (0,0,0)…(1,1,1) in kw-fastest order, out_last=0 throughout, first out_valid 2 edges after accept, in_ready back to 1 after the 8th beat.
- Rounding: N=8, in_data=0xFFFFFFFF → each beat is 0x00000000 with AVGPOOL3D_BWD_ROUND_EN defined, or 0xFFFFFFFF without it.
- Non-power-of-two: KD=KH=KW=3 (RECIP=2427), in_data=0x001B0000 (27.0) → 27 beats of 0x0000FFF9, final beat at indices (2,2,2).
- Backpressure and last: N=8, in_last=1, out_ready toggling 1,0,0,1… → out_data/indices stable while stalled, exactly 8 accepted beats, out_last=1 only on the (1,1,1) beat; in_valid held high during EMIT is not accepted until IDLE.
- Reset mid-window: assert rst after the 3rd accepted beat → out_valid=0 and busy=0 immediately (async); after release in_ready=1; a new input 0x00100000 yields 8 fresh beats of 0x00020000 starting at (0,0,0).
- Degenerate window: KD=KH=KW=1, in_data=0x80000000 → one beat 0x80000000, indices 0, out_last follows in_last.

Source files
------------

// File: rtl/avg_pool_3d_bwd_if.sv
// Stream interface for avg_pool_3d_bwd: pooled-gradient input side,
// scaled-gradient output side with window offsets, and the busy flag.
interface avg_pool_3d_bwd_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned KD     = 2,
    parameter int unsigned KH     = 2,
    parameter int unsigned KW     = 2
) ();
    localparam int unsigned IW_D = (KD > 1) ? $clog2(KD) : 1;
    localparam int unsigned IW_H = (KH > 1) ? $clog2(KH) : 1;
    localparam int unsigned IW_W = (KW > 1) ? $clog2(KW) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IW_D-1:0]   out_kd;
    logic [IW_H-1:0]   out_kh;
    logic [IW_W-1:0]   out_kw;
    logic              out_last;
    logic              busy;

    // Block-side view
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_kd, out_kh, out_kw, out_last, busy
    );

    // Environment-side view
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_kd, out_kh, out_kw, out_last, busy
    );
endinterface

// File: rtl/avg_pool_3d_bwd.sv
// Backward 3D average pooling: takes one pooled gradient, scales it by
// 1/(KD*KH*KW) in Q16.16 and replays it once per window element tagged
// with its (kd,kh,kw) offset, kw fastest.
// Optional build macro AVGPOOL3D_BWD_ROUND_EN selects round-half-up in the
// scaling step; without it the result truncates toward minus infinity.
module avg_pool_3d_bwd #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned KD     = 2,
    parameter int unsigned KH     = 2,
    parameter int unsigned KW     = 2
) (
    input  logic                clk,
    input  logic                rst,
    avg_pool_3d_bwd_if.slave    bus
);
    localparam int unsigned N       = KD * KH * KW;
    localparam int unsigned RECIP_I = (65536 + N / 2) / N;
    localparam logic [16:0] RECIP   = 17'(RECIP_I);
    localparam int unsigned IW_D    = (KD > 1) ? $clog2(KD) : 1;
    localparam int unsigned IW_H    = (KH > 1) ? $clog2(KH) : 1;
    localparam int unsigned IW_W    = (KW > 1) ? $clog2(KW) : 1;
    localparam int unsigned PW      = DATA_W + 18;

    localparam logic [IW_D-1:0] KD_MAX = IW_D'(KD - 1);
    localparam logic [IW_H-1:0] KH_MAX = IW_H'(KH - 1);
    localparam logic [IW_W-1:0] KW_MAX = IW_W'(KW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCALE = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic signed [DATA_W-1:0] r_hold;
    logic                     r_last_hold;
    logic [DATA_W-1:0]        r_scaled;
    logic [IW_D-1:0]          r_kd;
    logic [IW_H-1:0]          r_kh;
    logic [IW_W-1:0]          r_kw;

    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_fire;
    logic                     w_kd_wrap;
    logic                     w_kh_wrap;
    logic                     w_kw_wrap;
    logic                     w_final;
    logic signed [PW-1:0]     w_prod;
    logic signed [PW-1:0]     w_prod_rnd;

    // Handshake qualifiers and window-position decode
    assign w_in_ready = (r_state == S_IDLE) && !rst;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_fire     = (r_state == S_EMIT) && bus.out_ready;
    assign w_kd_wrap  = (r_kd == KD_MAX);
    assign w_kh_wrap  = (r_kh == KH_MAX);
    assign w_kw_wrap  = (r_kw == KW_MAX);
    assign w_final    = w_kd_wrap && w_kh_wrap && w_kw_wrap;

    // Full-precision signed product of the held gradient and the Q1.16 reciprocal
    assign w_prod = PW'(r_hold) * PW'($signed({1'b0, RECIP}));

`ifdef AVGPOOL3D_BWD_ROUND_EN
    assign w_prod_rnd = w_prod + PW'(32'sd32768);
`else
    assign w_prod_rnd = w_prod;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: accept, scale one cycle, then emit N beats
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_SCALE;
                end
            end
            S_SCALE: begin
                w_next = S_EMIT;
            end
            S_EMIT: begin
                if (w_fire && w_final) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Input hold registers, captured on the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_last_hold <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= $signed(bus.in_data);
            r_last_hold <= bus.in_last;
        end
    end

    // Scaled gradient, registered once per window and held through EMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scaled <= '0;
        end else if (r_state == S_SCALE) begin
            r_scaled <= DATA_W'(w_prod_rnd >>> 16);
        end
    end

    // Window offset counters: cleared in SCALE, kw fastest, advance only on a taken beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kd <= '0;
            r_kh <= '0;
            r_kw <= '0;
        end else if (r_state == S_SCALE) begin
            r_kd <= '0;
            r_kh <= '0;
            r_kw <= '0;
        end else if (w_fire) begin
            if (w_kw_wrap) begin
                r_kw <= '0;
                if (w_kh_wrap) begin
                    r_kh <= '0;
                    r_kd <= w_kd_wrap ? '0 : r_kd + IW_D'(1);
                end else begin
                    r_kh <= r_kh + IW_H'(1);
                end
            end else begin
                r_kw <= r_kw + IW_W'(1);
            end
        end
    end

    // Output decode from registered state
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_EMIT);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_data  = r_scaled;
    assign bus.out_kd    = r_kd;
    assign bus.out_kh    = r_kh;
    assign bus.out_kw    = r_kw;
    assign bus.out_last  = (r_state == S_EMIT) && r_last_hold && w_final;

endmodule
